// File: rtl/fifo_grey_read_pointer_if.sv
// Read-side bus of the async grey FIFO read pointer block.
// The slave modport is the pointer block itself; the master modport is the
// read-side consumer plus the write-domain grey pointer source.
interface fifo_grey_read_pointer_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0]   wr_ptr_grey_async;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   rd_ptr_grey;
   logic          empty;
   logic          almost_empty;
   logic [AW:0]   rd_count;
   logic          underflow;

   modport master (
      output wr_ptr_grey_async,
      output rd_en,
      input  rd_addr,
      input  rd_ptr_grey,
      input  empty,
      input  almost_empty,
      input  rd_count,
      input  underflow
   );

   modport slave (
      input  wr_ptr_grey_async,
      input  rd_en,
      output rd_addr,
      output rd_ptr_grey,
      output empty,
      output almost_empty,
      output rd_count,
      output underflow
   );
endinterface

// File: rtl/fifo_grey_read_pointer.sv
// Read-side pointer and status block of the asynchronous grey-coded FIFO.
// The write-domain grey pointer is synchronised into the read clock domain
// and decoded to binary only after the last synchroniser stage. The read
// pointer is kept in binary and grey form; empty, almost_empty, fill count
// and underflow are all registered from next-state values so that an
// accepted read is reflected in the status at the same edge.
module fifo_grey_read_pointer #(
   parameter int FIFO_DEPTH          = 8,
   parameter int SYNC_STAGES         = 2,
   parameter int ALMOST_EMPTY_THRESH = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   fifo_grey_read_pointer_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] THRESH_W = PW'(ALMOST_EMPTY_THRESH);

   // Grey to binary: MSB passes through, each lower bit folds in the bits above.
   function automatic logic [PW-1:0] grey_to_bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Binary to grey: adjacent binary values differ in exactly one grey bit.
   function automatic logic [PW-1:0] bin_to_grey(input logic [PW-1:0] b);
      return b ^ {1'b0, b[PW-1:1]};
   endfunction

   // Synchroniser chain; stage 0 is the first flop after the async input.
   logic [PW-1:0] sync_r [SYNC_STAGES];

   logic [PW-1:0] wsync_s;
   logic [PW-1:0] wbin_s;
   logic          rd_acc_s;
   logic [PW-1:0] rbin_next_s;
   logic [PW-1:0] rgrey_next_s;
   logic [PW-1:0] count_next_s;

   logic [PW-1:0] rbin_r;
   logic [AW-1:0] rd_addr_r;
   logic [PW-1:0] rd_ptr_grey_r;
   logic          empty_r;
   logic          almost_empty_r;
   logic [PW-1:0] rd_count_r;
   logic          underflow_r;

   assign wsync_s = sync_r[SYNC_STAGES-1];

   // Shift the write grey pointer through the synchroniser with no logic between stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= {PW{1'b0}};
         end
      end else begin
         sync_r[0] <= bus.wr_ptr_grey_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Next-state read pointer and fill count; reads are only accepted when the registered empty is low.
   always_comb begin
      wbin_s       = grey_to_bin(wsync_s);
      rd_acc_s     = bus.rd_en & ~empty_r;
      rbin_next_s  = rbin_r + {{AW{1'b0}}, rd_acc_s};
      rgrey_next_s = bin_to_grey(rbin_next_s);
      count_next_s = wbin_s - rbin_next_s;
   end

   // Register the read pointer, address and status flags from the next-state values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rbin_r         <= {PW{1'b0}};
         rd_addr_r      <= {AW{1'b0}};
         rd_ptr_grey_r  <= {PW{1'b0}};
         empty_r        <= 1'b1;
         almost_empty_r <= 1'b1;
         rd_count_r     <= {PW{1'b0}};
         underflow_r    <= 1'b0;
      end else begin
         rbin_r         <= rbin_next_s;
         rd_addr_r      <= rbin_next_s[AW-1:0];
         rd_ptr_grey_r  <= rgrey_next_s;
         empty_r        <= (rgrey_next_s == wsync_s);
         almost_empty_r <= (count_next_s <= THRESH_W);
         rd_count_r     <= count_next_s;
         underflow_r    <= bus.rd_en & empty_r;
      end
   end

   assign bus.rd_addr      = rd_addr_r;
   assign bus.rd_ptr_grey  = rd_ptr_grey_r;
   assign bus.empty        = empty_r;
   assign bus.almost_empty = almost_empty_r;
   assign bus.rd_count     = rd_count_r;
   assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_grey_read_pointer.sv
// Self-checking bench for fifo_grey_read_pointer (FIFO_DEPTH 8, 2 sync stages, threshold 1).
module tb_fifo_grey_read_pointer;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fifo_grey_read_pointer_if #(.FIFO_DEPTH(DEPTH)) bus ();

   fifo_grey_read_pointer #(
      .FIFO_DEPTH          (DEPTH),
      .SYNC_STAGES         (2),
      .ALMOST_EMPTY_THRESH (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] addr;
      logic [3:0] grey;
      logic       empty;
      logic       ae;
      logic [3:0] count;
      logic       uf;
   } want_t;

   typedef struct {
      logic [3:0] wr_grey;
      logic       rd_en;
      want_t      want;
   } vec_t;

   want_t sb_q[$];
   int    n_vec  = 0;
   int    n_miss = 0;

   // reference model state: synchroniser contents and read pointer as plain binary integers
   int    m_sync0, m_sync1, m_rptr;
   logic  m_empty;

   task automatic check_field(input string name, input logic [7:0] act, input logic [7:0] want);
      n_vec++;
      if (act !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input want_t w);
      check_field({tag, ".rd_addr"},      {5'b0, bus.rd_addr},      {5'b0, w.addr});
      check_field({tag, ".rd_ptr_grey"},  {4'b0, bus.rd_ptr_grey},  {4'b0, w.grey});
      check_field({tag, ".empty"},        {7'b0, bus.empty},        {7'b0, w.empty});
      check_field({tag, ".almost_empty"}, {7'b0, bus.almost_empty}, {7'b0, w.ae});
      check_field({tag, ".rd_count"},     {4'b0, bus.rd_count},     {4'b0, w.count});
      check_field({tag, ".underflow"},    {7'b0, bus.underflow},    {7'b0, w.uf});
   endtask

   function automatic want_t mk_want(input logic [2:0] a, input logic [3:0] g, input logic e,
                                     input logic ae, input logic [3:0] c, input logic u);
      want_t w;
      w.addr = a; w.grey = g; w.empty = e; w.ae = ae; w.count = c; w.uf = u;
      return w;
   endfunction

   function automatic logic [3:0] to_grey(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_sync0 = 0; m_sync1 = 0; m_rptr = 0; m_empty = 1'b1;
   endtask

   task automatic model_step(input int wbin, input logic rd, output want_t w);
      int acc, cnt;
      acc    = (rd && !m_empty) ? 1 : 0;
      w.uf   = rd && m_empty;
      m_rptr = (m_rptr + acc) % 16;
      cnt    = (m_sync1 - m_rptr + 16) % 16;
      m_empty = (cnt == 0);
      w.addr  = 3'(m_rptr % DEPTH);
      w.grey  = to_grey(m_rptr);
      w.empty = m_empty;
      w.count = 4'(cnt);
      w.ae    = (cnt <= 1);
      m_sync1 = m_sync0;
      m_sync0 = wbin;
   endtask

   // drive one cycle of stimulus, push its expectation, then compare after the edge
   task automatic apply(input string tag, input logic [3:0] wg, input logic rd, input want_t w);
      bus.wr_ptr_grey_async = wg;
      bus.rd_en             = rd;
      sb_q.push_back(w);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         check_outputs(tag, sb_q.pop_front());
      end
      check_field({tag, ".count_le_depth"}, {7'b0, (bus.rd_count <= 4'd8)}, 8'd1);
   endtask

   task automatic drive_model(input string tag, input int wbin, input logic rd);
      want_t w;
      model_step(wbin, rd, w);
      apply(tag, to_grey(wbin), rd, w);
   endtask

   vec_t  tbl[11];
   want_t rst_want;
   int    w_ptr;
   logic  [3:0] prev_grey;
   logic  saw_wrap;

   initial begin
      rst_want = mk_want(3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
      // wr_grey, rd_en, then expected addr, grey, empty, almost_empty, count, underflow after the edge
      tbl[0]  = '{4'b0001, 1'b0, mk_want(3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0)};
      tbl[1]  = '{4'b0001, 1'b0, mk_want(3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0)};
      tbl[2]  = '{4'b0001, 1'b0, mk_want(3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0)};
      tbl[3]  = '{4'b0011, 1'b0, mk_want(3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0)};
      tbl[4]  = '{4'b0011, 1'b0, mk_want(3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0)};
      tbl[5]  = '{4'b0011, 1'b0, mk_want(3'd0, 4'b0000, 1'b0, 1'b0, 4'd2, 1'b0)};
      tbl[6]  = '{4'b0011, 1'b1, mk_want(3'd1, 4'b0001, 1'b0, 1'b1, 4'd1, 1'b0)};
      tbl[7]  = '{4'b0011, 1'b1, mk_want(3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b0)};
      tbl[8]  = '{4'b0011, 1'b1, mk_want(3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b1)};
      tbl[9]  = '{4'b0011, 1'b0, mk_want(3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b0)};
      tbl[10] = '{4'b0011, 1'b0, mk_want(3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b0)};

      // reset drops between edges and takes effect without a clock
      bus.wr_ptr_grey_async = 4'b0101;
      bus.rd_en             = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_outputs("t1_async_reset", rst_want);
      @(negedge clk);
      bus.wr_ptr_grey_async = 4'b0000;
      @(negedge clk);
      reset = 1'b1;

      // fill, read down to empty, then underflow
      for (int i = 0; i < 11; i++) begin
         apply($sformatf("t2_4_vec%0d", i), tbl[i].wr_grey, tbl[i].rd_en, tbl[i].want);
      end

      // reset mid-operation discards pointers immediately
      #2;
      bus.wr_ptr_grey_async = 4'b0000;
      reset = 1'b0;
      #1;
      check_outputs("t5_mid_reset", rst_want);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      sb_q.delete();

      // full FIFO: pointer 8 arrives after three edges, then eight reads
      for (int i = 0; i < 3; i++) drive_model($sformatf("t5_sync%0d", i), 8, 1'b0);
      check_field("t5_count_full", {4'b0, bus.rd_count}, 8'd8);
      for (int i = 0; i < 8; i++) drive_model($sformatf("t5_read%0d", i), 8, 1'b1);
      check_field("t5_grey_end", {4'b0, bus.rd_ptr_grey}, 8'h0C);
      check_field("t5_empty_end", {7'b0, bus.empty}, 8'd1);
      drive_model("t5_underflow", 8, 1'b1);
      drive_model("t5_after_uf", 8, 1'b0);

      // wrap: writer walks all sixteen codes, one read per entry
      w_ptr    = 8;
      saw_wrap = 1'b0;
      for (int i = 0; i < 16; i++) begin
         w_ptr = (w_ptr + 1) % 16;
         for (int k = 0; k < 3; k++) drive_model($sformatf("t6_w%0d_idle%0d", i, k), w_ptr, 1'b0);
         prev_grey = bus.rd_ptr_grey;
         drive_model($sformatf("t6_w%0d_read", i), w_ptr, 1'b1);
         check_field($sformatf("t6_onebit%0d", i),
                     8'($countones(bus.rd_ptr_grey ^ prev_grey)), 8'd1);
         if (prev_grey == 4'b1000 && bus.rd_ptr_grey == 4'b0000 && bus.rd_addr == 3'd0) begin
            saw_wrap = 1'b1;
         end
      end
      check_field("t6_wrap_seen", {7'b0, saw_wrap}, 8'd1);

      // mixed traffic: reads racing pointer arrivals, writer kept legal
      for (int i = 0; i < 60; i++) begin
         if (((w_ptr - m_rptr + 16) % 16) < DEPTH && $urandom_range(0, 1) == 1) begin
            w_ptr = (w_ptr + 1) % 16;
         end
         drive_model($sformatf("mix%0d", i), w_ptr, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
